// File: rtl/vga_out_seq_pkg.sv
// Shared types for the VGA pong start-up / output-mode sequencer.
package vga_out_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    POR       = 2'd1,
    RUN       = 2'd2,
    SWITCH    = 2'd3
  } state_t;

  localparam logic SEL_8BIT  = 1'b0;
  localparam logic SEL_12BIT = 1'b1;

endpackage

// File: rtl/vga_out_sequencer_sync_2ff.sv
// Two-flop synchroniser bank for slow asynchronous board/PLL inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_d, s1_q;
  logic [WIDTH-1:0] s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/vga_out_sequencer.sv
// Start-up and PMOD pinout controller for the VGA pong core (25.125 MHz domain).
// Optional build macro LOCK_LOSS_RESET_EN: losing PLL lock after start-up returns to WAIT_LOCK.
module vga_out_sequencer
  import vga_out_seq_pkg::*;
#(
  parameter int   POR_CYCLES   = 1024,
  parameter int   LOCK_FILT    = 16,
  parameter int   BLANK_FRAMES = 2,
  parameter logic SEL_DEFAULT  = SEL_8BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       user_rst_req,
  input  logic       sel_req,
  input  logic       vs_in,
  output logic       core_rst,
  output logic       sel_active,
  output logic       blank,
  output logic [1:0] state_o
);

  localparam int PW = $clog2(POR_CYCLES + 1);
  localparam int LW = $clog2(LOCK_FILT + 1);
  localparam int FW = $clog2(BLANK_FRAMES + 1);

  localparam logic [PW-1:0] POR_LOAD  = PW'(POR_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FILT - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLANK_FRAMES - 1);

  logic [2:0] sync_out;
  logic       sync_lock, sync_urst, sync_sel;

  sync_2ff #(.WIDTH(3)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({pll_locked, user_rst_req, sel_req}),
    .q     (sync_out)
  );

  assign sync_lock = sync_out[2];
  assign sync_urst = sync_out[1];
  assign sync_sel  = sync_out[0];

  state_t          state_d, state_q;
  logic [LW-1:0]   lock_cnt_d, lock_cnt_q;
  logic [PW-1:0]   por_cnt_d, por_cnt_q;
  logic [FW-1:0]   frm_cnt_d, frm_cnt_q;
  logic            core_rst_d, core_rst_q;
  logic            blank_d, blank_q;
  logic            sel_active_d, sel_active_q;
  logic            urst_hold_d, urst_hold_q;
  logic            vs_d, vs_q;
  logic            vs_prev_d, vs_prev_q;
  logic            fe;

  assign fe = vs_prev_q & ~vs_q;

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    por_cnt_d    = por_cnt_q;
    frm_cnt_d    = frm_cnt_q;
    core_rst_d   = core_rst_q;
    blank_d      = blank_q;
    sel_active_d = sel_active_q;
    urst_hold_d  = urst_hold_q;
    vs_d         = vs_in;
    vs_prev_d    = vs_q;

    case (state_q)
      WAIT_LOCK: begin
        core_rst_d = 1'b1;
        blank_d    = 1'b1;
        if (!sync_lock) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d    = POR;
          por_cnt_d  = POR_LOAD;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end

      POR: begin
        core_rst_d = 1'b1;
        blank_d    = 1'b1;
        // Only a request that caused this POR can extend it; fresh requests here are ignored.
        urst_hold_d = urst_hold_q & sync_urst;
        if (urst_hold_q && sync_urst) begin
          por_cnt_d = POR_LOAD;
        end else if (por_cnt_q == '0) begin
          state_d    = RUN;
          core_rst_d = 1'b0;
          blank_d    = 1'b0;
        end else begin
          por_cnt_d = por_cnt_q - 1'b1;
        end
      end

      RUN: begin
        core_rst_d = 1'b0;
        blank_d    = 1'b0;
        if (sync_urst) begin
          state_d     = POR;
          por_cnt_d   = POR_LOAD;
          core_rst_d  = 1'b1;
          blank_d     = 1'b1;
          urst_hold_d = 1'b1;
        end else if (fe && (sync_sel != sel_active_q)) begin
          state_d      = SWITCH;
          sel_active_d = sync_sel;
          blank_d      = 1'b1;
          frm_cnt_d    = '0;
        end
      end

      SWITCH: begin
        core_rst_d = 1'b0;
        blank_d    = 1'b1;
        if (sync_urst) begin
          state_d     = POR;
          por_cnt_d   = POR_LOAD;
          core_rst_d  = 1'b1;
          urst_hold_d = 1'b1;
        end else if (fe) begin
          if (frm_cnt_q == FRM_LAST) begin
            state_d = RUN;
            blank_d = 1'b0;
          end else begin
            frm_cnt_d = frm_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

`ifdef LOCK_LOSS_RESET_EN
    // Lock loss overrides every other transition once past WAIT_LOCK.
    if ((state_q != WAIT_LOCK) && !sync_lock) begin
      state_d     = WAIT_LOCK;
      core_rst_d  = 1'b1;
      blank_d     = 1'b1;
      lock_cnt_d  = '0;
      urst_hold_d = 1'b0;
    end
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= WAIT_LOCK;
      lock_cnt_q   <= '0;
      por_cnt_q    <= '0;
      frm_cnt_q    <= '0;
      core_rst_q   <= 1'b1;
      blank_q      <= 1'b1;
      sel_active_q <= SEL_DEFAULT;
      urst_hold_q  <= 1'b0;
      vs_q         <= 1'b1;
      vs_prev_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      por_cnt_q    <= por_cnt_d;
      frm_cnt_q    <= frm_cnt_d;
      core_rst_q   <= core_rst_d;
      blank_q      <= blank_d;
      sel_active_q <= sel_active_d;
      urst_hold_q  <= urst_hold_d;
      vs_q         <= vs_d;
      vs_prev_q    <= vs_prev_d;
    end
  end

  assign core_rst   = core_rst_q;
  assign blank      = blank_q;
  assign sel_active = sel_active_q;
  assign state_o    = state_q;

endmodule
